mod12_hour_tracker: RTL and testbench

Downstream consumer of the 4-bit mod-12 loadable up counter. Samples the counter's q output and converts it to a 12-hour BCD display value (0 shown as 12). Keeps an AM/PM flag and counts full days across 11->0 wraps. Flags discontinuities caused by loads or resets of the upstream counter, and flags illegal codes (12..15).

---
 rtl/mod12_hour_tracker.sv | 129 ++++++++++++
 tb/tb_mod12_hour_tracker.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mod12_hour_tracker.sv
// Turns samples of an upstream mod-12 counter into a 12-hour BCD display.
// Also tracks AM/PM and completed days, and flags jumps and illegal codes.
module mod12_hour_tracker #(
  parameter int unsigned DAY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       q_in,
  output logic [3:0]       hour_tens,
  output logic [3:0]       hour_ones,
  output logic             pm,
  output logic [DAY_W-1:0] day_cnt,
  output logic             wrap_pulse,
  output logic             jump_pulse,
  output logic             illegal
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               pm_q, pm_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic               wrap_q, wrap_d;
  logic               jump_q, jump_d;
  logic               illegal_q, illegal_d;

  // Counter value 0 is displayed as hour 12; other values map directly.
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input logic [CNT_W-1:0] v);
    logic [2*DIGIT_W-1:0] bcd;
    case (v)
      4'd0:    bcd = {4'd1, 4'd2};
      4'd10:   bcd = {4'd1, 4'd0};
      4'd11:   bcd = {4'd1, 4'd1};
      default: bcd = {4'd0, v};
    endcase
    return bcd;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      tens_q    <= DIGIT_W'(1);
      ones_q    <= DIGIT_W'(2);
      pm_q      <= 1'b0;
      day_q     <= '0;
      wrap_q    <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      pm_q      <= pm_d;
      day_q     <= day_d;
      wrap_q    <= wrap_d;
      jump_q    <= jump_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    pm_d      = pm_q;
    day_d     = day_q;
    wrap_d    = 1'b0;
    jump_d    = 1'b0;
    illegal_d = illegal_q;

    if (en && (state_q != ST_FAULT)) begin
      if (q_in >= 4'd12) begin
        // Illegal code: freeze everything and stay faulted until reset.
        illegal_d = 1'b1;
        state_d   = ST_FAULT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            prev_d           = q_in;
            {tens_d, ones_d} = to_bcd(q_in);
            state_d          = ST_TRACK;
          end
          ST_TRACK: begin
            if (q_in == prev_q) begin
              prev_d = prev_q;
            end else if ((prev_q == 4'd11) && (q_in == 4'd0)) begin
              wrap_d           = 1'b1;
              pm_d             = ~pm_q;
              if (pm_q) day_d  = day_q + DAY_W'(1);
              prev_d           = q_in;
              {tens_d, ones_d} = to_bcd(q_in);
            end else if (q_in == (prev_q + 4'd1)) begin
              prev_d           = q_in;
              {tens_d, ones_d} = to_bcd(q_in);
            end else begin
              jump_d           = 1'b1;
              prev_d           = q_in;
              {tens_d, ones_d} = to_bcd(q_in);
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign hour_tens  = tens_q;
  assign hour_ones  = ones_q;
  assign pm         = pm_q;
  assign day_cnt    = day_q;
  assign wrap_pulse = wrap_q;
  assign jump_pulse = jump_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mod12_hour_tracker.sv
// Randomized and directed checks of mod12_hour_tracker against a behavioural hour model.
module tb_mod12_hour_tracker;

  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    q_in = 4'd0;
  logic [3:0]    hour_tens, hour_ones;
  logic          pm;
  logic [DW-1:0] day_cnt;
  logic          wrap_pulse, jump_pulse, illegal;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_started, m_faulted, m_pm, m_wrap, m_jump, m_illegal;
  int m_prev, m_day;

  mod12_hour_tracker #(.DAY_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in),
    .hour_tens(hour_tens), .hour_ones(hour_ones), .pm(pm), .day_cnt(day_cnt),
    .wrap_pulse(wrap_pulse), .jump_pulse(jump_pulse), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_faulted = 0; m_pm = 0; m_wrap = 0; m_jump = 0;
    m_illegal = 0; m_prev = 0; m_day = 0;
  endtask

  // One rising edge of the hour tracker, described in clock-face terms.
  task automatic model_edge(input bit e, input int q);
    m_wrap = 0;
    m_jump = 0;
    if (e && !m_faulted) begin
      if (q >= 12) begin
        m_illegal = 1;
        m_faulted = 1;
      end else if (!m_started) begin
        m_started = 1;
        m_prev = q;
      end else if (q == m_prev) begin
        m_prev = q;
      end else if (m_prev == 11 && q == 0) begin
        m_wrap = 1;
        if (m_pm) m_day = (m_day + 1) % (1 << DW);
        m_pm = !m_pm;
        m_prev = 0;
      end else if (q == (m_prev + 1) % 12) begin
        m_prev = q;
      end else begin
        m_jump = 1;
        m_prev = q;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int hour;
    hour = (m_prev == 0) ? 12 : m_prev;
    check({tag, ".tens"}, int'(hour_tens), hour / 10);
    check({tag, ".ones"}, int'(hour_ones), hour % 10);
    check({tag, ".pm"}, int'(pm), int'(m_pm));
    check({tag, ".day"}, int'(day_cnt), m_day);
    check({tag, ".wrap"}, int'(wrap_pulse), int'(m_wrap));
    check({tag, ".jump"}, int'(jump_pulse), int'(m_jump));
    check({tag, ".ill"}, int'(illegal), int'(m_illegal));
  endtask

  task automatic step(input string tag, input bit e, input int q);
    @(negedge clk);
    en = e;
    q_in = 4'(q);
    @(posedge clk);
    model_edge(e, q);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    int q;
    int r;
    do_reset("por");

    // First sample leaves IDLE, then count up through a wrap to PM.
    step("first", 1, 3);
    for (int v = 4; v <= 12; v++) step("count", 1, v % 12);

    // Seven more full turns: four PM->AM wraps roll the 2-bit day counter to 0.
    for (int t = 0; t < 7; t++)
      for (int v = 1; v <= 12; v++) step("turn", 1, v % 12);

    // Upstream loads look like jumps, including a jump onto 0.
    step("to5", 1, 5);
    step("load8", 1, 8);
    step("jump0", 1, 0);

    // Stalls and disabled samples.
    step("hold6a", 1, 6);
    step("hold6b", 1, 6);
    step("hold6c", 1, 6);
    step("en_lo", 0, 9);

    // Illegal code freezes the tracker until reset.
    step("to7", 1, 7);
    step("bad13", 1, 13);
    step("frozen8", 1, 8);
    step("frozen_en0", 0, 0);
    do_reset("rst_fault");
    step("post_rst", 1, 9);

    // Randomized traffic dominated by legal +1 steps.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        do_reset("rnd_rst");
      end else begin
        if (r < 600)      q = (m_prev + 1) % 12;
        else if (r < 700) q = m_prev;
        else if (r < 995) q = int'($urandom_range(0, 11));
        else              q = int'($urandom_range(12, 15));
        step("rnd", ($urandom_range(0, 9) != 0), q);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
